// File: rtl/chesstypes.sv
// Shared chess types: 6-bit square encoding {row, col}, field extraction
// helpers and the king direction-offset table indexed by direction number.
package chesstypes;

  typedef logic [5:0] square_t;

  typedef struct packed {
    logic signed [3:0] drow;
    logic signed [3:0] dcol;
  } offset_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

  // Clockwise from "up one row", starting at direction 0.
  localparam offset_t KING_DIRS [0:7] = '{
    '{drow:  4'sd1, dcol:  4'sd0},
    '{drow:  4'sd1, dcol:  4'sd1},
    '{drow:  4'sd0, dcol:  4'sd1},
    '{drow: -4'sd1, dcol:  4'sd1},
    '{drow: -4'sd1, dcol:  4'sd0},
    '{drow: -4'sd1, dcol: -4'sd1},
    '{drow:  4'sd0, dcol: -4'sd1},
    '{drow:  4'sd1, dcol: -4'sd1}
  };

  function automatic logic [2:0] row(input square_t sq);
    return sq[5:3];
  endfunction

  function automatic logic [2:0] col(input square_t sq);
    return sq[2:0];
  endfunction

endpackage

// File: rtl/king_step_decode.sv
// Combinational king-step decode: origin square plus direction number gives
// the wrapped candidate row/col and whether the unwrapped sum is on the board.
module king_step_decode
  import chesstypes::*;
(
  input  square_t    origin,
  input  logic [2:0] number,
  output logic [2:0] cand_row,
  output logic [2:0] cand_col,
  output logic       on_board
);

  offset_t           step_s;
  logic signed [3:0] row_sum_s;
  logic signed [3:0] col_sum_s;

  // 4-bit signed sums: off-board results show up as negative or as 8 (wraps to -8).
  always_comb begin
    step_s    = KING_DIRS[number];
    row_sum_s = $signed({1'b0, chesstypes::row(origin)}) + step_s.drow;
    col_sum_s = $signed({1'b0, chesstypes::col(origin)}) + step_s.dcol;
    on_board  = (row_sum_s >= 4'sd0) && (row_sum_s <= 4'sd7) &&
                (col_sum_s >= 4'sd0) && (col_sum_s <= 4'sd7);
    cand_row  = row_sum_s[2:0];
    cand_col  = col_sum_s[2:0];
  end

endmodule

// File: rtl/king_move_sequencer.sv
// Emits the 8 king-step candidates of a latched origin, one per clock.
// Optional build macro KING_ZERO_INVALID_EN zeroes row/col/out_pos when invalid.
module king_move_sequencer
  import chesstypes::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] pos,
  output logic [2:0] number,
  output logic       active,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic       valid,
  output logic [5:0] out_pos
);

  seq_state_t state_r;
  seq_state_t state_nxt_s;
  logic [2:0] number_r;
  logic [2:0] number_nxt_s;
  square_t    origin_r;
  square_t    origin_nxt_s;
  logic [2:0] cand_row_s;
  logic [2:0] cand_col_s;
  logic       on_board_s;

  // State, direction counter and latched origin registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      number_r <= 3'd0;
      origin_r <= 6'd0;
    end else begin
      state_r  <= state_nxt_s;
      number_r <= number_nxt_s;
      origin_r <= origin_nxt_s;
    end
  end

  // Next-state logic: accept start only while idle, run exactly 8 directions.
  always_comb begin
    state_nxt_s  = state_r;
    number_nxt_s = number_r;
    origin_nxt_s = origin_r;
    case (state_r)
      ST_IDLE: begin
        number_nxt_s = 3'd0;
        if (start) begin
          state_nxt_s  = ST_RUN;
          origin_nxt_s = pos;
        end else begin
          state_nxt_s  = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (number_r == 3'd7) begin
          state_nxt_s  = ST_IDLE;
          number_nxt_s = 3'd0;
        end else begin
          state_nxt_s  = ST_RUN;
          number_nxt_s = number_r + 3'd1;
        end
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        number_nxt_s = 3'd0;
      end
    endcase
  end

  king_step_decode u_decode (
    .origin   (origin_r),
    .number   (number_r),
    .cand_row (cand_row_s),
    .cand_col (cand_col_s),
    .on_board (on_board_s)
  );

  // Output view of the current candidate.
  always_comb begin
    active = (state_r == ST_RUN);
    number = number_r;
    valid  = active && on_board_s;
`ifdef KING_ZERO_INVALID_EN
    if (valid) begin
      row = cand_row_s;
      col = cand_col_s;
    end else begin
      row = 3'd0;
      col = 3'd0;
    end
`else
    row = cand_row_s;
    col = cand_col_s;
`endif
    out_pos = {row, col};
  end

endmodule

// File: tb/tb_king_move_sequencer.sv
// Directed self-checking bench for king_move_sequencer; expected candidates
// are hand-computed from the king direction table.
module tb_king_move_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] pos;
  logic [2:0] number;
  logic       active;
  logic [2:0] row;
  logic [2:0] col;
  logic       valid;
  logic [5:0] out_pos;

  int total;
  int bad;

  king_move_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .pos     (pos),
    .number  (number),
    .active  (active),
    .row     (row),
    .col     (col),
    .valid   (valid),
    .out_pos (out_pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    pos   = 6'd0;
    #12;
    total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b exp=0", active); end
    total++; if (number !== 3'd0) begin bad++; $display("FAIL reset_number got=%0d exp=0", number); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    total++; if (out_pos !== 6'o10) begin bad++; $display("FAIL reset_out_pos got=%o exp=10", out_pos); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (active !== 1'b0) begin bad++; $display("FAIL idle_after_reset got=%b exp=0", active); end
  endtask

  // Starts at a negedge in IDLE; returns at a negedge in IDLE (or at the
  // restart point when hold is set and start stays high).
  task automatic run_sequence(input string name, input logic [5:0] origin,
                              input logic [7:0] exp_valid,
                              input logic [7:0][5:0] exp_pos, input bit hold);
    pos   = origin;
    start = 1'b1;
    total++; if (active !== 1'b0 || number !== 3'd0) begin
      bad++; $display("FAIL %s_pre active=%b number=%0d exp 0/0", name, active, number);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      pos = ~origin;
      total++; if (active !== 1'b1) begin bad++; $display("FAIL %s_active n=%0d got=%b exp=1", name, i, active); end
      total++; if (number !== i[2:0]) begin bad++; $display("FAIL %s_number got=%0d exp=%0d", name, number, i); end
      total++; if (valid !== exp_valid[i]) begin bad++; $display("FAIL %s_valid n=%0d got=%b exp=%b", name, i, valid, exp_valid[i]); end
      if (exp_valid[i]) begin
        total++; if (out_pos !== exp_pos[i]) begin bad++; $display("FAIL %s_out_pos n=%0d got=%o exp=%o", name, i, out_pos, exp_pos[i]); end
        total++; if ({row, col} !== exp_pos[i]) begin bad++; $display("FAIL %s_rowcol n=%0d got=%0d,%0d exp=%o", name, i, row, col, exp_pos[i]); end
      end
    end
    @(negedge clk);
    total++; if (active !== 1'b0 || number !== 3'd0 || valid !== 1'b0) begin
      bad++; $display("FAIL %s_post active=%b number=%0d valid=%b exp 0/0/0", name, active, number, valid);
    end
  endtask

  task automatic test_center();
    run_sequence("center22", 6'o22, 8'hFF,
      {6'o31, 6'o21, 6'o11, 6'o12, 6'o13, 6'o23, 6'o33, 6'o32}, 1'b0);
  endtask

  task automatic test_corner_low();
    run_sequence("corner00", 6'o00, 8'b0000_0111,
      {6'o00, 6'o00, 6'o00, 6'o00, 6'o00, 6'o01, 6'o11, 6'o10}, 1'b0);
  endtask

  task automatic test_top_edge();
    run_sequence("edge74", 6'o74, 8'b0111_1100,
      {6'o00, 6'o73, 6'o63, 6'o64, 6'o65, 6'o75, 6'o00, 6'o00}, 1'b0);
  endtask

  task automatic test_corner_high();
    run_sequence("corner77", 6'o77, 8'b0111_0000,
      {6'o00, 6'o76, 6'o66, 6'o67, 6'o00, 6'o00, 6'o00, 6'o00}, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_sequence("b2b61", 6'o61, 8'hFF,
      {6'o70, 6'o60, 6'o50, 6'o51, 6'o52, 6'o62, 6'o72, 6'o71}, 1'b1);
    pos = 6'o61;
    @(negedge clk);
    start = 1'b0;
    total++; if (active !== 1'b1 || number !== 3'd0) begin
      bad++; $display("FAIL b2b_restart active=%b number=%0d exp 1/0", active, number);
    end
    total++; if (out_pos !== 6'o71 || valid !== 1'b1) begin
      bad++; $display("FAIL b2b_restart_pos got=%o valid=%b exp=71/1", out_pos, valid);
    end
    repeat (8) @(negedge clk);
    total++; if (active !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", active); end
  endtask

  task automatic test_reset_mid_run();
    pos   = 6'o33;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    pos   = 6'o00;
    start = 1'b1;
    @(negedge clk);
    total++; if (active !== 1'b1 || number !== 3'd3) begin
      bad++; $display("FAIL midrun_state active=%b number=%0d exp 1/3", active, number);
    end
    total++; if (out_pos !== 6'o24 || valid !== 1'b1) begin
      bad++; $display("FAIL midrun_latched got=%o valid=%b exp=24/1", out_pos, valid);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (active !== 1'b0 || number !== 3'd0 || valid !== 1'b0) begin
      bad++; $display("FAIL async_reset active=%b number=%0d valid=%b exp 0/0/0", active, number, valid);
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (active !== 1'b0 || number !== 3'd0) begin
      bad++; $display("FAIL post_reset_idle active=%b number=%0d exp 0/0", active, number);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_center();
    test_corner_low();
    test_top_edge();
    test_corner_high();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
